// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl_if
//  Brief    : Control/display bundle between a host and the 4-digit
//             7-segment scan controller.
//  Revision : 1.0  initial release
// ============================================================================
interface seg_scan_ctrl_if;
  logic        en;         // 1 = display on, 0 = all digits dark
  logic        load;       // one-cycle strobe: capture din/dp_in into shadow
  logic [15:0] din;        // BCD digits, [3:0] = rightmost digit
  logic [3:0]  dp_in;      // decimal point per digit, 1 = lit
  logic        blank_lz;   // 1 = blank leading zero digits
  logic [3:0]  pos_idx;    // digit index to position decoder, 4'hF = none
  logic [3:0]  digit_bcd;  // BCD nibble of digit shown, 4'hF when dark
  logic        dp_on;      // decimal point of digit shown
  logic        pend;       // shadow holds an uncommitted value

  // Host side: drives controls and data, observes display outputs.
  modport master (
    output en, load, din, dp_in, blank_lz,
    input  pos_idx, digit_bcd, dp_on, pend
  );

  // Controller side.
  modport slave (
    input  en, load, din, dp_in, blank_lz,
    output pos_idx, digit_bcd, dp_on, pend
  );
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl
//  Brief    : Time-multiplexed scan controller for a 4-digit 7-segment
//             display. Double-buffered BCD value with frame-aligned
//             (tear-free) commit, leading-zero blanking and display enable.
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int DIV_COUNT = 50000,  // clk cycles per digit slot, >= 2
  parameter int CNT_W     = 16      // prescaler width, 2**CNT_W >= DIV_COUNT
) (
  input  wire logic          clk,
  input  wire logic          rst,
  seg_scan_ctrl_if.slave     bus
);

  localparam logic [CNT_W-1:0] c_PRESC_LAST = CNT_W'(DIV_COUNT - 1);
  localparam logic [3:0]       c_DARK       = 4'hF;

  logic [CNT_W-1:0] r_presc;
  logic [1:0]       r_idx;
  logic [15:0]      r_active;
  logic [3:0]       r_active_dp;
  logic [15:0]      r_shadow;
  logic [3:0]       r_shadow_dp;
  logic             r_pend;
  logic [3:0]       r_pos_idx;
  logic [3:0]       r_digit_bcd;
  logic             r_dp_on;

  logic             w_tick;
  logic             w_commit;
  logic             w_lz;
  logic             w_dark;
  logic [3:0]       w_nibble;
  logic             w_dp;

  // Slot tick and frame-wrap commit qualifier.
  always_comb begin
    w_tick   = (r_presc == c_PRESC_LAST);
    w_commit = w_tick && (r_idx == 2'd3) && r_pend;
  end

  // Select the current digit and decide whether it is dark; a digit is a
  // leading zero when it and every more-significant nibble are zero.
  always_comb begin
    w_lz     = 1'b0;
    w_nibble = r_active[3:0];
    w_dp     = r_active_dp[0];
    case (r_idx)
      2'd1: begin
        w_lz     = (r_active[15:4] == 12'h000);
        w_nibble = r_active[7:4];
        w_dp     = r_active_dp[1];
      end
      2'd2: begin
        w_lz     = (r_active[15:8] == 8'h00);
        w_nibble = r_active[11:8];
        w_dp     = r_active_dp[2];
      end
      2'd3: begin
        w_lz     = (r_active[15:12] == 4'h0);
        w_nibble = r_active[15:12];
        w_dp     = r_active_dp[3];
      end
      default: begin
        w_lz     = 1'b0;
        w_nibble = r_active[3:0];
        w_dp     = r_active_dp[0];
      end
    endcase
    w_dark = !bus.en || (bus.blank_lz && w_lz);
  end

  // Prescaler: free-running 0..DIV_COUNT-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + CNT_W'(1);
    end
  end

  // Digit index advances once per slot and wraps naturally at 3.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= 2'd0;
    end else if (w_tick) begin
      r_idx <= r_idx + 2'd1;
    end
  end

  // Double buffer: loads land in the shadow, which moves to the active
  // buffer only at a frame wrap so a frame never mixes two values. A load
  // on the commit tick still commits the old shadow and stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active    <= 16'h0000;
      r_active_dp <= 4'h0;
      r_shadow    <= 16'h0000;
      r_shadow_dp <= 4'h0;
      r_pend      <= 1'b0;
    end else begin
      if (w_commit) begin
        r_active    <= r_shadow;
        r_active_dp <= r_shadow_dp;
      end
      if (bus.load) begin
        r_shadow    <= bus.din;
        r_shadow_dp <= bus.dp_in;
        r_pend      <= 1'b1;
      end else if (w_commit) begin
        r_pend      <= 1'b0;
      end
    end
  end

  // Registered display outputs, one cycle behind index/enable/blanking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos_idx   <= c_DARK;
      r_digit_bcd <= c_DARK;
      r_dp_on     <= 1'b0;
    end else if (w_dark) begin
      r_pos_idx   <= c_DARK;
      r_digit_bcd <= c_DARK;
      r_dp_on     <= 1'b0;
    end else begin
      r_pos_idx   <= {2'b00, r_idx};
      r_digit_bcd <= w_nibble;
      r_dp_on     <= w_dp;
    end
  end

  assign bus.pos_idx   = r_pos_idx;
  assign bus.digit_bcd = r_digit_bcd;
  assign bus.dp_on     = r_dp_on;
  assign bus.pend      = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_ctrl
//  Brief    : Self-checking bench for seg_scan_ctrl with DIV_COUNT=4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_ctrl_if bus_if();

  seg_scan_ctrl #(.DIV_COUNT(DIV), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: time since reset release defines the digit slot.
  bit          m_valid = 1'b0;
  int          n       = 0;
  logic [15:0] m_act   = 16'h0;
  logic [15:0] m_sh    = 16'h0;
  logic [3:0]  m_adp   = 4'h0;
  logic [3:0]  m_sdp   = 4'h0;
  bit          m_pend  = 1'b0;
  int          m_idx;
  bit          m_tick, m_dark, m_commit;
  logic [3:0]  e_pos, e_bcd;
  logic        e_dp;

  task automatic chk4(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model update and per-cycle comparison.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_valid = 1'b1;
        n = 0;
        m_act = 16'h0; m_sh = 16'h0; m_adp = 4'h0; m_sdp = 4'h0; m_pend = 1'b0;
        e_pos = 4'hF; e_bcd = 4'hF; e_dp = 1'b0;
      end else if (m_valid) begin
        m_idx  = (n / DIV) % 4;
        m_tick = ((n % DIV) == DIV - 1);
        m_dark = !bus_if.en ||
                 (bus_if.blank_lz && m_idx != 0 && (m_act >> (4 * m_idx)) == 16'h0);
        e_pos  = m_dark ? 4'hF : 4'(m_idx);
        e_bcd  = m_dark ? 4'hF : 4'((m_act >> (4 * m_idx)) & 16'hF);
        e_dp   = m_dark ? 1'b0 : m_adp[m_idx];
        m_commit = m_tick && (m_idx == 3) && m_pend;
        if (m_commit) begin
          m_act = m_sh;
          m_adp = m_sdp;
        end
        if (bus_if.load) begin
          m_sh = bus_if.din; m_sdp = bus_if.dp_in; m_pend = 1'b1;
        end else if (m_commit) begin
          m_pend = 1'b0;
        end
        n++;
      end
      if (m_valid) begin
        #1;
        chk4("model_pos_idx",   bus_if.pos_idx,   e_pos);
        chk4("model_digit_bcd", bus_if.digit_bcd, e_bcd);
        chk4("model_dp_on",     {3'b000, bus_if.dp_on}, {3'b000, e_dp});
        chk4("model_pend",      {3'b000, bus_if.pend},  {3'b000, m_pend});
      end
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Advance to the negedge before the edge whose frame phase is m.
  task automatic wait_mod(input int m);
    int g;
    g = 0;
    while ((n % FRAME) != m && g < 64) begin
      @(negedge clk);
      g++;
    end
    if ((n % FRAME) != m) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_mod: phase %0d not reached, at %0d", m, n % FRAME);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
    bus_if.load  = 1'b1;
    bus_if.din   = d;
    bus_if.dp_in = dp;
    @(negedge clk);
    bus_if.load  = 1'b0;
  endtask

  // Directed stimulus with literal expectations.
  initial begin
    rst = 1'b1;
    bus_if.en = 1'b1; bus_if.load = 1'b0; bus_if.din = 16'h0;
    bus_if.dp_in = 4'h0; bus_if.blank_lz = 1'b0;

    // 1: reset values, then the scan sequence.
    step(3);
    chk4("rst_pos",  bus_if.pos_idx,   4'hF);
    chk4("rst_bcd",  bus_if.digit_bcd, 4'hF);
    chk4("rst_dp",   {3'b000, bus_if.dp_on}, 4'h0);
    chk4("rst_pend", {3'b000, bus_if.pend},  4'h0);
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      chk4("scan_seq", bus_if.pos_idx, 4'(((k - 1) / 4) % 4));
    end

    // 2: mid-frame load commits only at the frame wrap.
    wait_mod(5);
    do_load(16'h1234, 4'b0100);
    chk4("t2_pend_set", {3'b000, bus_if.pend}, 4'h1);
    wait_mod(13);
    chk4("t2_old_bcd", bus_if.digit_bcd, 4'h0);
    chk4("t2_pend_hold", {3'b000, bus_if.pend}, 4'h1);
    for (int k = 0; k < 4; k++) begin
      wait_mod(1 + 4 * k);
      chk4("t2_pos", bus_if.pos_idx, 4'(k));
      chk4("t2_bcd", bus_if.digit_bcd, 4'(4 - k));
      chk4("t2_dp", {3'b000, bus_if.dp_on}, (k == 2) ? 4'h1 : 4'h0);
    end
    chk4("t2_pend_clr", {3'b000, bus_if.pend}, 4'h0);

    // 3: leading-zero blanking of 0050.
    wait_mod(2);
    bus_if.blank_lz = 1'b1;
    do_load(16'h0050, 4'b0000);
    wait_mod(1);
    chk4("t3_b_pos0", bus_if.pos_idx, 4'h0);
    chk4("t3_b_bcd0", bus_if.digit_bcd, 4'h0);
    wait_mod(5);
    chk4("t3_b_pos1", bus_if.pos_idx, 4'h1);
    chk4("t3_b_bcd1", bus_if.digit_bcd, 4'h5);
    wait_mod(9);
    chk4("t3_b_pos2", bus_if.pos_idx, 4'hF);
    chk4("t3_b_bcd2", bus_if.digit_bcd, 4'hF);
    wait_mod(13);
    chk4("t3_b_pos3", bus_if.pos_idx, 4'hF);
    bus_if.blank_lz = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_mod(1 + 4 * k);
      chk4("t3_nb_pos", bus_if.pos_idx, 4'(k));
      chk4("t3_nb_bcd", bus_if.digit_bcd, (k == 1) ? 4'h5 : 4'h0);
    end

    // 4: load on the commit tick while pending.
    wait_mod(5);
    do_load(16'h2222, 4'b0001);
    wait_mod(15);
    do_load(16'h1111, 4'b0000);
    chk4("t4_pend", {3'b000, bus_if.pend}, 4'h1);
    wait_mod(1);
    chk4("t4_bcd_old", bus_if.digit_bcd, 4'h2);
    chk4("t4_dp_old", {3'b000, bus_if.dp_on}, 4'h1);
    wait_mod(13);
    wait_mod(1);
    chk4("t4_bcd_new", bus_if.digit_bcd, 4'h1);
    chk4("t4_dp_new", {3'b000, bus_if.dp_on}, 4'h0);
    chk4("t4_pend_clr", {3'b000, bus_if.pend}, 4'h0);

    // Load on the wrap tick with nothing pending commits one frame later.
    wait_mod(15);
    do_load(16'h3333, 4'b0000);
    chk4("t4b_pend", {3'b000, bus_if.pend}, 4'h1);
    wait_mod(1);
    chk4("t4b_bcd_old", bus_if.digit_bcd, 4'h1);
    step(1);
    wait_mod(1);
    chk4("t4b_bcd_new", bus_if.digit_bcd, 4'h3);
    chk4("t4b_pend_clr", {3'b000, bus_if.pend}, 4'h0);

    // 5: display disable while the scan keeps running.
    wait_mod(0);
    bus_if.en = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk4("t5_dark_pos", bus_if.pos_idx, 4'hF);
      chk4("t5_dark_bcd", bus_if.digit_bcd, 4'hF);
    end
    bus_if.en = 1'b1;
    step(1);
    chk4("t5_resume_pos", bus_if.pos_idx, 4'h2);
    chk4("t5_resume_bcd", bus_if.digit_bcd, 4'h3);

    // 6: reset while a load is pending discards the shadow.
    wait_mod(6);
    do_load(16'h9999, 4'b1111);
    chk4("t6_pend", {3'b000, bus_if.pend}, 4'h1);
    rst = 1'b1;
    step(1);
    chk4("t6_rst_pos",  bus_if.pos_idx, 4'hF);
    chk4("t6_rst_bcd",  bus_if.digit_bcd, 4'hF);
    chk4("t6_rst_dp",   {3'b000, bus_if.dp_on}, 4'h0);
    chk4("t6_rst_pend", {3'b000, bus_if.pend}, 4'h0);
    step(1);
    rst = 1'b0;
    for (int k = 1; k <= 2 * FRAME; k++) begin
      step(1);
      chk4("t6_pos", bus_if.pos_idx, 4'(((k - 1) / 4) % 4));
      chk4("t6_bcd", bus_if.digit_bcd, 4'h0);
      chk4("t6_dp", {3'b000, bus_if.dp_on}, 4'h0);
    end

    step(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

endmodule
`default_nettype wire
